xor_session_ctrl: RTL

Top-level sequencer for the serial XOR encryption datapath. It runs one session at a time in this order: optional key load, message load, wait for encryption, then wait for the ciphertext to be shifted out. It gates the key/message deserializer load flags from a host data strobe, checks that the datapath bit counters agree with its own counts, and supervises each wait with a watchdog. It reports busy, done and error status to the host pins.

---
 rtl/xor_session_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/xor_session_ctrl.sv
// Session sequencer for the serial XOR encryption datapath: key load, message
// load, encrypt wait and serializer wait, each supervised by a watchdog.
module xor_session_ctrl #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          iStart,
  input  logic                          iRekey,
  input  logic                          iAbort,
  input  logic                          iData_valid,
  input  logic [$clog2(KEY_SIZE):0]     iKey_count,
  input  logic [$clog2(MSG_SIZE):0]     iMsg_count,
  input  logic                          iEnc_status,
  input  logic                          iSer_flag,
  output logic                          oKey_flag,
  output logic                          oMsg_flag,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oError,
  output logic [1:0]                    oErr_code,
  output logic [2:0]                    oState
);

  localparam int KCW = $clog2(KEY_SIZE) + 1;
  localparam int MCW = $clog2(MSG_SIZE) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KEY  = 3'd1,
    LOAD_MSG  = 3'd2,
    ENCRYPT   = 3'd3,
    SERIALIZE = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  state_t     state, state_next;
  logic [6:0] bit_cnt, bit_cnt_next;
  logic [7:0] wdog, wdog_next;
  logic       key_valid, key_valid_next;
  logic [1:0] err_code, err_next;
  logic       ser_prev;
  logic       ser_seen, ser_seen_next;
  logic       key_accept, msg_accept, bit_accept;
  logic       wait_state, timeout_hit;

  // Only bits up to the configured width are forwarded; the rest are dropped.
  assign key_accept = ena & ~iAbort & (state == LOAD_KEY) & iData_valid
                      & (bit_cnt < 7'(KEY_SIZE));
  assign msg_accept = ena & ~iAbort & (state == LOAD_MSG) & iData_valid
                      & (bit_cnt < 7'(MSG_SIZE));
  assign bit_accept = key_accept | msg_accept;

  assign wait_state  = (state == LOAD_KEY) || (state == LOAD_MSG) ||
                       (state == ENCRYPT)  || (state == SERIALIZE);
  assign timeout_hit = wait_state && (wdog == 8'(TIMEOUT - 1)) && !bit_accept;

  assign oKey_flag = key_accept;
  assign oMsg_flag = msg_accept;
  assign oBusy     = (state != IDLE);
  assign oDone     = (state == DONE);
  assign oError    = (state == ERROR);
  assign oErr_code = err_code;
  assign oState    = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      wdog      <= '0;
      key_valid <= 1'b0;
      err_code  <= 2'b00;
      ser_prev  <= 1'b0;
      ser_seen  <= 1'b0;
    end else if (ena) begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      wdog      <= wdog_next;
      key_valid <= key_valid_next;
      err_code  <= err_next;
      ser_prev  <= iSer_flag;
      ser_seen  <= ser_seen_next;
    end
  end

  // Completion checks are tested before the watchdog so they win a tie.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    wdog_next      = wdog;
    key_valid_next = key_valid;
    err_next       = err_code;
    ser_seen_next  = ser_seen;

    if (bit_accept) bit_cnt_next = bit_cnt + 7'd1;
    if (wait_state) wdog_next = bit_accept ? 8'd0 : wdog + 8'd1;

    if (iAbort) begin
      state_next = IDLE;
      err_next   = 2'b00;
      if (state == LOAD_KEY) key_valid_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            if (iRekey) begin
              state_next     = LOAD_KEY;
              key_valid_next = 1'b0;
            end else if (key_valid) begin
              state_next = LOAD_MSG;
            end else begin
              state_next = ERROR;
              err_next   = 2'b01;
            end
          end
        end
        LOAD_KEY: begin
          if (bit_cnt == 7'(KEY_SIZE)) begin
            if (iKey_count == KCW'(KEY_SIZE)) begin
              state_next     = LOAD_MSG;
              key_valid_next = 1'b1;
            end else begin
              state_next = ERROR;
              err_next   = 2'b11;
            end
          end else if (timeout_hit) begin
            state_next = ERROR;
            err_next   = 2'b10;
          end
        end
        LOAD_MSG: begin
          if (bit_cnt == 7'(MSG_SIZE)) begin
            if (iMsg_count == MCW'(MSG_SIZE)) begin
              state_next = ENCRYPT;
            end else begin
              state_next = ERROR;
              err_next   = 2'b11;
            end
          end else if (timeout_hit) begin
            state_next = ERROR;
            err_next   = 2'b10;
          end
        end
        ENCRYPT: begin
          if (iEnc_status) begin
            state_next = SERIALIZE;
          end else if (timeout_hit) begin
            state_next = ERROR;
            err_next   = 2'b10;
          end
        end
        SERIALIZE: begin
          ser_seen_next = ser_seen | (iSer_flag & ~ser_prev);
          if (ser_seen && ser_prev && !iSer_flag) begin
            state_next = DONE;
          end else if (timeout_hit) begin
            state_next = ERROR;
            err_next   = 2'b10;
          end
        end
        DONE:    state_next = IDLE;
        ERROR:   state_next = ERROR;
        default: state_next = IDLE;
      endcase
    end

    if (state_next != state) begin
      bit_cnt_next  = '0;
      wdog_next     = '0;
      ser_seen_next = 1'b0;
    end
  end

endmodule
